// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage with the IF/ID pipeline register. Owns the PC,
//   requests instruction words over a req/ready handshake, parks one returned
//   word in a skid buffer while ID is stalled, applies branch/jump redirects
//   from ID, and drives the decoder opcode from the ID-stage instruction.
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   imem_req       out  fetch request valid
//   imem_addr      out  byte address of the fetch (= pc)
//   imem_ready     in   imem_rdata is valid this cycle
//   imem_rdata     in   returned instruction word
//   stall          in   ID cannot accept a new instruction
//   branch_taken   in   ID-stage branch resolved taken
//   branch_target  in   byte target for branch_taken
//   jump           in   ID-stage J-type jump
//   id_valid       out  IF/ID holds a live instruction
//   id_instr       out  IF/ID instruction (0 when not valid)
//   id_pc4         out  address of the ID instruction + 4
//   op             out  id_instr[31:26], to the control decoder
// ---------------------------------------------------------------------------
module fetch_stage #(
   parameter int unsigned          IMEM_AW  = 32,
   parameter logic [IMEM_AW-1:0]   RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic               imem_ready,
   input  logic [31:0]        imem_rdata,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [31:0]        branch_target,
   input  logic               jump,
   output logic               id_valid,
   output logic [31:0]        id_instr,
   output logic [31:0]        id_pc4,
   output logic [5:0]         op
);

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic               started_q, started_d;
   logic [IMEM_AW-1:0] pc_q, pc_d;
   logic               id_valid_q, id_valid_d;
   logic [31:0]        id_instr_q, id_instr_d;
   logic [31:0]        id_pc4_q, id_pc4_d;
   logic [31:0]        skid_instr_q, skid_instr_d;
   logic [31:0]        skid_pc4_q, skid_pc4_d;

   logic               redirect;
   logic               fetch_ok;
   logic [31:0]        redirect_target;
   logic [IMEM_AW-1:0] pc_plus4;

   // Instruction addresses are word aligned; the low two bits never reach pc.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'd3;
   endfunction

   // J-type target: region bits of the ID instruction's pc+4 plus the 26-bit
   // word index from the instruction.
   function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                               input logic [31:0] instr);
      return {pc4[31:28], instr[25:0], 2'b00};
   endfunction

   assign redirect        = branch_taken | jump;
   assign redirect_target = branch_taken ? word_align(branch_target)
                                         : jump_target(id_pc4_q, id_instr_q);
   // Wraps modulo 2^IMEM_AW by construction.
   assign pc_plus4        = pc_q + IMEM_AW'(4);

   // started_q keeps the request low for the reset cycle and releases it on
   // the first clock after rst_n deasserts.
   assign imem_req  = started_q & (state_q == FETCH);
   assign imem_addr = pc_q;
   // A return without a request is not a fetch.
   assign fetch_ok  = imem_req & imem_ready;

   assign id_valid = id_valid_q;
   assign id_instr = id_instr_q;
   assign id_pc4   = id_pc4_q;
   assign op       = id_instr_q[31:26];

   always_comb begin
      state_d      = state_q;
      started_d    = 1'b1;
      pc_d         = pc_q;
      id_valid_d   = id_valid_q;
      id_instr_d   = id_instr_q;
      id_pc4_d     = id_pc4_q;
      skid_instr_d = skid_instr_q;
      skid_pc4_d   = skid_pc4_q;

      if (redirect) begin
         // Flush: any word returned this cycle and any parked word are lost.
         pc_d       = redirect_target[IMEM_AW-1:0];
         id_valid_d = 1'b0;
         id_instr_d = '0;
         state_d    = FETCH;
      end else begin
         case (state_q)
            FETCH: begin
               if (stall) begin
                  if (fetch_ok) begin
                     skid_instr_d = imem_rdata;
                     skid_pc4_d   = 32'(pc_plus4);
                     pc_d         = pc_plus4;
                     state_d      = HOLD;
                  end
               end else if (fetch_ok) begin
                  id_valid_d = 1'b1;
                  id_instr_d = imem_rdata;
                  id_pc4_d   = 32'(pc_plus4);
                  pc_d       = pc_plus4;
               end else begin
                  // Bubble: a zero word decodes as a NOP downstream.
                  id_valid_d = 1'b0;
                  id_instr_d = '0;
               end
            end
            HOLD: begin
               if (!stall) begin
                  id_valid_d = 1'b1;
                  id_instr_d = skid_instr_q;
                  id_pc4_d   = skid_pc4_q;
                  state_d    = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= FETCH;
         started_q    <= 1'b0;
         pc_q         <= RESET_PC;
         id_valid_q   <= 1'b0;
         id_instr_q   <= '0;
         id_pc4_q     <= '0;
         skid_instr_q <= '0;
         skid_pc4_q   <= '0;
      end else begin
         state_q      <= state_d;
         started_q    <= started_d;
         pc_q         <= pc_d;
         id_valid_q   <= id_valid_d;
         id_instr_q   <= id_instr_d;
         id_pc4_q     <= id_pc4_d;
         skid_instr_q <= skid_instr_d;
         skid_pc4_q   <= skid_pc4_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. A transaction-level model tracks the
//   architectural view (pc, ID slot, an optional parked word) and is compared
//   against the DUT every falling clock edge; literal expectations at chosen
//   points pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc4;
   logic [5:0]  op;

   int checks = 0;
   int errors = 0;

   fetch_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .id_valid      (id_valid),
      .id_instr      (id_instr),
      .id_pc4        (id_pc4),
      .op            (op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory contents.
   function automatic logic [31:0] imem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h8C01_0004;
         32'h0000_0004: return 32'h3C01_1234;
         32'h0000_0008: return 32'h0022_1820;
         32'h0000_000C: return 32'hAC03_0008;
         32'h1000_0004: return 32'h0800_0010;
         default:       return 32'hAC00_0000 ^ a;
      endcase
   endfunction

   // Garbage on the bus when not ready, so a DUT using it would be caught.
   always_comb imem_rdata = imem_ready ? imem_word(imem_addr) : 32'hDEAD_BEEF;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic        started;
      logic        held;
      logic        idv;
      logic [31:0] pc;
      logic [31:0] idi;
      logic [31:0] idp4;
      logic [31:0] hi;
      logic [31:0] hp4;
   } m_t;

   m_t m;

   function automatic m_t m_reset();
      m_t r;
      r = '0;
      r.pc = 32'h0000_0000;
      return r;
   endfunction

   function automatic m_t model_step(input m_t s, input logic stl,
                                     input logic bt, input logic [31:0] btgt,
                                     input logic jmp, input logic rdy);
      m_t n;
      logic got;
      logic [31:0] word;
      n    = s;
      got  = s.started && !s.held && rdy;
      word = imem_word(s.pc);
      n.started = 1'b1;
      if (bt || jmp) begin
         n.pc   = bt ? {btgt[31:2], 2'b00} : {s.idp4[31:28], s.idi[25:0], 2'b00};
         n.idv  = 1'b0;
         n.idi  = 32'h0;
         n.held = 1'b0;
      end else if (s.held) begin
         if (!stl) begin
            n.idv  = 1'b1;
            n.idi  = s.hi;
            n.idp4 = s.hp4;
            n.held = 1'b0;
         end
      end else if (stl) begin
         if (got) begin
            n.held = 1'b1;
            n.hi   = word;
            n.hp4  = s.pc + 32'd4;
            n.pc   = s.pc + 32'd4;
         end
      end else if (got) begin
         n.idv  = 1'b1;
         n.idi  = word;
         n.idp4 = s.pc + 32'd4;
         n.pc   = s.pc + 32'd4;
      end else begin
         n.idv = 1'b0;
         n.idi = 32'h0;
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= m_reset();
      else        m <= model_step(m, stall, branch_taken, branch_target, jump, imem_ready);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      chk("m_req",   32'(imem_req), 32'(m.started && !m.held));
      chk("m_addr",  imem_addr, m.pc);
      chk("m_valid", 32'(id_valid), 32'(m.idv));
      chk("m_instr", id_instr, m.idi);
      chk("m_pc4",   id_pc4, m.idp4);
      chk("m_op",    32'(op), 32'(m.idi[31:26]));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
      jump = 1'b0; imem_ready = 1'b1;
      repeat (2) step();
      chk("rst_req",   32'(imem_req), 32'h0);
      chk("rst_addr",  imem_addr, 32'h0);
      chk("rst_valid", 32'(id_valid), 32'h0);
      chk("rst_pc4",   id_pc4, 32'h0);
      rst_n = 1'b1;

      // 1: streaming fetch
      step();
      chk("t1_req",   32'(imem_req), 32'h1);
      chk("t1_addr0", imem_addr, 32'h0);
      step();
      chk("t1_instr0", id_instr, 32'h8C01_0004);
      chk("t1_op23",   32'(op), 32'h23);
      chk("t1_pc4_4",  id_pc4, 32'h4);
      chk("t1_addr4",  imem_addr, 32'h4);
      step();
      chk("t1_instr1", id_instr, 32'h3C01_1234);
      chk("t1_pc4_8",  id_pc4, 32'h8);

      // 2: stall with ready at pc=8
      stall = 1'b1;
      step();
      chk("t2_req0",  32'(imem_req), 32'h0);
      chk("t2_pc4",   id_pc4, 32'h8);
      step();
      step();
      stall = 1'b0;
      step();
      chk("t2_pc4_c",  id_pc4, 32'hC);
      chk("t2_valid",  32'(id_valid), 32'h1);
      chk("t2_instr",  id_instr, 32'h0022_1820);
      chk("t2_req1",   32'(imem_req), 32'h1);
      chk("t2_addr_c", imem_addr, 32'hC);
      step();
      chk("t2_next",   id_instr, 32'hAC03_0008);
      chk("t2_pc4_10", id_pc4, 32'h10);

      // 3: branch at pc=0x10, low target bits ignored
      branch_taken = 1'b1; branch_target = 32'h43;
      step();
      branch_taken = 1'b0;
      chk("t3_valid", 32'(id_valid), 32'h0);
      chk("t3_instr", id_instr, 32'h0);
      chk("t3_addr",  imem_addr, 32'h40);
      step();
      chk("t3_pc4",   id_pc4, 32'h44);

      // 4: jump from 0x1000_0004
      branch_taken = 1'b1; branch_target = 32'h1000_0004;
      step();
      branch_taken = 1'b0;
      step();
      chk("t4_instr", id_instr, 32'h0800_0010);
      chk("t4_pc4",   id_pc4, 32'h1000_0008);
      jump = 1'b1;
      step();
      jump = 1'b0;
      chk("t4_addr",  imem_addr, 32'h1000_0040);
      chk("t4_valid", 32'(id_valid), 32'h0);
      step();

      // 5: memory not ready at pc=4
      branch_taken = 1'b1; branch_target = 32'h4;
      step();
      branch_taken = 1'b0; imem_ready = 1'b0;
      step();
      chk("t5_addr_a",  imem_addr, 32'h4);
      chk("t5_valid_a", 32'(id_valid), 32'h0);
      chk("t5_op_a",    32'(op), 32'h0);
      step();
      chk("t5_addr_b",  imem_addr, 32'h4);
      chk("t5_valid_b", 32'(id_valid), 32'h0);
      imem_ready = 1'b1;
      step();
      chk("t5_instr", id_instr, 32'h3C01_1234);
      chk("t5_pc4",   id_pc4, 32'h8);

      // branch beats jump, redirect beats stall, pc wraps
      branch_taken = 1'b1; jump = 1'b1; stall = 1'b1; branch_target = 32'hFFFF_FFFC;
      step();
      branch_taken = 1'b0; jump = 1'b0; stall = 1'b0;
      chk("w_addr",  imem_addr, 32'hFFFF_FFFC);
      chk("w_req",   32'(imem_req), 32'h1);
      step();
      chk("w_pc4",   id_pc4, 32'h0);
      chk("w_addr0", imem_addr, 32'h0);
      chk("w_instr", id_instr, 32'h53FF_FFFC);

      // stall without ready holds everything in FETCH
      stall = 1'b1; imem_ready = 1'b0;
      step();
      chk("s_req",   32'(imem_req), 32'h1);
      chk("s_addr",  imem_addr, 32'h0);
      chk("s_instr", id_instr, 32'h53FF_FFFC);
      imem_ready = 1'b1;
      step();
      chk("s_hold", 32'(imem_req), 32'h0);
      // redirect out of HOLD discards the parked word
      branch_taken = 1'b1; branch_target = 32'h8;
      step();
      branch_taken = 1'b0;
      chk("h_addr",  imem_addr, 32'h8);
      chk("h_req",   32'(imem_req), 32'h1);
      chk("h_valid", 32'(id_valid), 32'h0);
      step();
      chk("h_hold", 32'(imem_req), 32'h0);

      // 6: reset pulse while in HOLD
      #2 rst_n = 1'b0;
      #1;
      chk("r6_req",   32'(imem_req), 32'h0);
      chk("r6_addr",  imem_addr, 32'h0);
      chk("r6_valid", 32'(id_valid), 32'h0);
      chk("r6_instr", id_instr, 32'h0);
      chk("r6_pc4",   id_pc4, 32'h0);
      step();
      rst_n = 1'b1; stall = 1'b0;
      step();
      chk("r6_req1",   32'(imem_req), 32'h1);
      chk("r6_addr0",  imem_addr, 32'h0);
      chk("r6_nostale", 32'(id_valid), 32'h0);
      step();
      chk("r6_instr0", id_instr, 32'h8C01_0004);
      chk("r6_pc4_4",  id_pc4, 32'h4);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage with IF/ID pipeline register, directly upstream of the main control decoder.
- Owns the PC, issues requests to instruction memory over a req/ready handshake, and buffers one returned word when ID is stalled.
- Applies branch/jump redirects from ID and presents the current ID-stage instruction; its opcode field drives the decoder's op input.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_AW, 32, width of the instruction address.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  IMEM_AW  byte address of the fetch (= pc).
- imem_ready  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  instruction word, valid when imem_ready.
- stall  in  1  ID cannot accept a new instruction; hold IF/ID.
- branch_taken  in  1  ID-stage branch resolved taken.
- branch_target  in  32  byte target for branch_taken.
- jump  in  1  ID-stage J-type jump.
- id_valid  out  1  IF/ID holds a live instruction.
- id_instr  out  32  IF/ID instruction; 0 when not valid.
- id_pc4  out  32  address of the ID instruction + 4.
- op  out  6  id_instr[31:26], to the control decoder.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; id_valid=0; id_instr=0; id_pc4=0; buffer empty.
  - State=FETCH; imem_req=0 while in reset, 1 from the first clock after release.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
  - HOLD: word captured in the skid buffer; imem_req=0.
- Redirect:
  - redirect = branch_taken | jump.
  - Target = branch_taken ? branch_target : {id_pc4[31:28], id_instr[25:0], 2'b00}.
  - If both are asserted, branch_taken wins.
- Priority per cycle: redirect > stall > normal advance.
- FETCH, imem_ready=1, no stall, no redirect:
  - id_instr<=imem_rdata, id_pc4<=pc+4, id_valid<=1, pc<=pc+4.
  - Sustained throughput is 1 instruction/cycle with a ready-every-cycle memory.
- FETCH, imem_ready=0, no stall, no redirect:
  - If ID is not stalled, id_valid<=0 and id_instr<=0 (bubble); pc unchanged.
- FETCH, imem_ready=1 and stall=1:
  - Word goes to the skid buffer with pc+4; pc<=pc+4; go to HOLD.
  - IF/ID is unchanged.
- FETCH, imem_ready=0 and stall=1: IF/ID unchanged, pc unchanged, stay in FETCH.
- HOLD, stall=1: everything held.
- HOLD, stall=0: buffer moves to IF/ID (id_valid<=1); go to FETCH. First new request is issued the following cycle.
- Redirect, in any state:
  - pc<=target; id_valid<=0, id_instr<=0 next cycle (flush); skid buffer discarded; state<=FETCH.
  - A word returned the same cycle (imem_ready=1) is dropped.
  - Redirect overrides stall.
- Handshake:
  - imem_addr may change while imem_req=1 without a prior imem_ready (abandoned fetch). Memory treats each cycle independently.
  - imem_ready is ignored when imem_req=0.
- Arithmetic: pc+4 is modulo 2^IMEM_AW; 32'hFFFF_FFFC wraps to 0. pc[1:0] is always 00; branch_target[1:0] is ignored (forced 0).
- op is purely combinational from id_instr. A flushed or bubble slot yields op=0 with id_instr=0 (sll $0 NOP).
- Reset mid-operation: all state returns to reset values immediately; an in-flight return is ignored.

Test Plan:
1. Reset then imem_ready=1 every cycle, rdata=8C010004, 3C... sequence -> imem_addr 0,4,8,...
   - id_pc4 4,8,C,... one cycle after each address.
   - op=6'h23 when id_instr=8C010004.
2. stall=1 for 3 cycles with ready=1 at pc=8 -> word at 8 captured in the skid buffer, state HOLD, imem_req=0.
   - On stall release, id_pc4=C and id_valid=1.
   - Next imem_addr=C; no instruction lost or duplicated.
3. branch_taken=1, branch_target=0x40 while ready=1 at pc=0x10 -> word at 0x10 dropped.
   - id_valid=0 next cycle, next imem_addr=0x40.
4. jump=1 with id_instr=08000010 (J-type), id_pc4=0x1000_0008 -> next imem_addr=0x1000_0040, one flush bubble.
5. imem_ready low for 2 cycles at pc=4 -> imem_addr held at 4, two bubbles with id_valid=0 and op=0, then normal flow.
6. rst_n pulsed low mid-stream while in HOLD -> outputs return to reset values immediately.
   - Fetch restarts at RESET_PC with no stale instruction emitted.
   - Also check pc=FFFF_FFFC wraps to 0.
